// File: rtl/comparator_pipe_if.sv
// rtl/comparator_pipe_if.sv - operand/result handshake bundle for comparator_pipe
interface comparator_pipe_if #(
  parameter int WIDTH = 16
);
  // request side: operands and compare mode
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;

  // response side: one-hot result flags
  logic             out_valid;
  logic             out_ready;
  logic             a_less_b;
  logic             a_greater_b;
  logic             a_equal_b;

  // master issues compares and consumes results
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, a_less_b, a_greater_b, a_equal_b
  );

  // slave is the comparator itself
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, a_less_b, a_greater_b, a_equal_b
  );
endinterface

// File: rtl/comparator_pipe.sv
// rtl/comparator_pipe.sv - pipelined MSB-first magnitude comparator, CHUNK bits per stage
module comparator_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  comparator_pipe_if.slave   bus
);

  localparam int STAGES = WIDTH / CHUNK;

  typedef enum logic [1:0] {
    DEC_UND = 2'd0,
    DEC_LT  = 2'd1,
    DEC_GT  = 2'd2
  } dec_e;

  // Per-stage state. The remaining operand bits are kept left-aligned so
  // every stage reads its chunk from the same MSB slice; the low bits that
  // have already been consumed are shifted-in zeros and trim away.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  dec_e              dec_q   [STAGES];
  dec_e              dec_d   [STAGES];
  logic [WIDTH-1:0]  rem_a_q [STAGES];
  logic [WIDTH-1:0]  rem_b_q [STAGES];
  logic [WIDTH-1:0]  rem_a_d [STAGES];
  logic [WIDTH-1:0]  rem_b_d [STAGES];

  // Inputs seen by each stage: stage 0 reads the port, the rest read the
  // register of the stage in front of them.
  dec_e              dec_in  [STAGES];
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [CHUNK-1:0]  chunk_a [STAGES];
  logic [CHUNK-1:0]  chunk_b [STAGES];

  logic              adv;
  logic [WIDTH-1:0]  a_t;
  logic [WIDTH-1:0]  b_t;

  // The whole pipe moves together; it only freezes when a finished result
  // is sitting at the output and nobody is taking it.
  assign adv          = ~valid_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;

  // Flipping the sign bit maps two's complement order onto unsigned order,
  // so only stage 0 ever needs to know the mode.
  assign a_t = {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
  assign b_t = {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};

  // next-state for every stage: resolve one chunk unless already decided
  always_comb begin
    src_a[0]   = a_t;
    src_b[0]   = b_t;
    dec_in[0]  = DEC_UND;
    valid_d[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = rem_a_q[k-1];
      src_b[k]   = rem_b_q[k-1];
      dec_in[k]  = dec_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk_a[k] = src_a[k][WIDTH-1 -: CHUNK];
      chunk_b[k] = src_b[k][WIDTH-1 -: CHUNK];
      if (dec_in[k] != DEC_UND) begin
        dec_d[k] = dec_in[k];
      end else if (chunk_a[k] < chunk_b[k]) begin
        dec_d[k] = DEC_LT;
      end else if (chunk_a[k] > chunk_b[k]) begin
        dec_d[k] = DEC_GT;
      end else begin
        dec_d[k] = DEC_UND;
      end
      rem_a_d[k] = src_a[k] << CHUNK;
      rem_b_d[k] = src_b[k] << CHUNK;
    end
  end

  // stage registers: cleared asynchronously, loaded only when the pipe advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dec_q[k]   <= DEC_UND;
        rem_a_q[k] <= '0;
        rem_b_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        dec_q[k]   <= dec_d[k];
        rem_a_q[k] <= rem_a_d[k];
        rem_b_q[k] <= rem_b_d[k];
      end
    end
  end

  // Flags decode straight from the last stage's registers, gated by its
  // valid bit, so they hold while stalled and vanish with the reset.
  assign bus.out_valid   = valid_q[STAGES-1];
  assign bus.a_less_b    = valid_q[STAGES-1] & (dec_q[STAGES-1] == DEC_LT);
  assign bus.a_greater_b = valid_q[STAGES-1] & (dec_q[STAGES-1] == DEC_GT);
  assign bus.a_equal_b   = valid_q[STAGES-1] & (dec_q[STAGES-1] == DEC_UND);

  // result port invariants: one-hot while valid, silent while idle, frozen while stalled
  a_onehot : assert property (@(posedge clk) disable iff (rst)
    bus.out_valid |-> $onehot({bus.a_less_b, bus.a_greater_b, bus.a_equal_b}));
  a_idle_zero : assert property (@(posedge clk) disable iff (rst)
    !bus.out_valid |-> ({bus.a_less_b, bus.a_greater_b, bus.a_equal_b} == 3'b000));
  a_stall_hold : assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable({bus.a_less_b, bus.a_greater_b, bus.a_equal_b})));

endmodule
